ic_tag_array: RTL and testbench

IC_TAG_ARRAY -- requirements
Module: ic_tag_array

---
 rtl/ic_pkg.sv | 27 ++
 rtl/ic_tag_way.sv | 73 +++++++
 rtl/ic_tag_array.sv | 156 +++++++++++++++
 tb/tb_ic_tag_array.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// ============================================================================
// Module   : ic_pkg
// Purpose  : Shared types for the instruction-cache tag array.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ic_pkg;

    typedef enum logic [0:0] {
        BEHAVIORAL = 1'b0,
        GOWIN      = 1'b1
    } impl_e;

    localparam impl_e IMPL = BEHAVIORAL;

    localparam int unsigned C_TAG_W_DEF = 15;

    // Default-width view of a RAM entry; modules build their own TAG_W-wide copy.
    typedef struct packed {
        logic                   valid;
        logic [C_TAG_W_DEF-1:0] tag;
    } tag_entry_t;

endpackage

`default_nettype wire

// File: rtl/ic_tag_way.sv
// ============================================================================
// Module   : ic_tag_way
// Purpose  : One way of the tag store: 1R1W RAM with same-set write forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ic_tag_way #(
    parameter int unsigned     SETS  = 256,
    parameter int unsigned     TAG_W = 15,
    parameter ic_pkg::impl_e   IMPL  = ic_pkg::IMPL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [$clog2(SETS)-1:0] rd_set,
    input  logic                    wr_en,
    input  logic [$clog2(SETS)-1:0] wr_set,
    input  logic [TAG_W:0]          wr_data,
    output logic [TAG_W:0]          rd_data
);
    import ic_pkg::*;

    logic [TAG_W:0] r_mem [SETS];
    logic [TAG_W:0] r_q;
    logic [TAG_W:0] r_fwd;
    logic           r_coll;
    logic           w_coll;

    assign w_coll = rd_en & wr_en & (rd_set == wr_set);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_set] <= wr_data;
        end
    end

    // Forwarding path is shared; only the RAM read-port enable differs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_coll <= 1'b0;
        end else if (rd_en) begin
            r_coll <= w_coll;
        end
    end

    always_ff @(posedge clk) begin
        if (w_coll) begin
            r_fwd <= wr_data;
        end
    end

    generate
        if (IMPL == GOWIN) begin : g_gowin
            always_ff @(posedge clk) begin
                if (rd_en && !w_coll) begin
                    r_q <= r_mem[rd_set];
                end
            end
        end else begin : g_behav
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    r_q <= r_mem[rd_set];
                end
            end
        end
    endgenerate

    assign rd_data = r_coll ? r_fwd : r_q;

endmodule

`default_nettype wire

// File: rtl/ic_tag_array.sv
// ============================================================================
// Module   : ic_tag_array
// Purpose  : N-way tag array with 1-cycle lookup, victim choice and flush sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ic_tag_array #(
    parameter int unsigned   WAYS  = 2,
    parameter int unsigned   SETS  = 256,
    parameter int unsigned   TAG_W = 15,
    parameter ic_pkg::impl_e IMPL  = ic_pkg::IMPL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [$clog2(SETS)-1:0] rd_set,
    input  logic [TAG_W-1:0]        rd_tag,
    output logic                    lk_valid,
    output logic                    hit,
    output logic [WAYS-1:0]         hit_way,
    output logic                    multi_hit,
    output logic [WAYS-1:0]         victim_way,
    input  logic                    wr_en,
    input  logic [$clog2(SETS)-1:0] wr_set,
    input  logic [WAYS-1:0]         wr_way,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic                    flush,
    output logic                    busy
);
    import ic_pkg::*;

    localparam int unsigned SET_W = $clog2(SETS);
    localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                      r_state;
    logic [SET_W-1:0]            r_sweep_set;
    logic [PTR_W-1:0]            r_ptr;
    logic [PTR_W-1:0]            r_ptr_snap;
    logic                        r_lk_valid;
    logic                        r_res_ok;
    logic [TAG_W-1:0]            r_tag;

    logic                        w_rd_acc;
    logic                        w_wr_acc;
    logic                        w_ptr_adv;
    logic [PTR_W-1:0]            w_ptr_nxt;
    logic [WAYS-1:0]             w_ptr_oh;
    logic [SET_W-1:0]            w_wset;
    logic [TAG_W:0]              w_wdata;
    logic [WAYS-1:0]             w_we;
    logic [WAYS-1:0][TAG_W:0]    w_rdata;
    logic [WAYS-1:0]             w_match;
    logic [WAYS-1:0]             w_invalid;

    assign busy      = (r_state == SWEEP);
    assign w_rd_acc  = rd_en & ~busy;
    assign w_wr_acc  = wr_en & ~busy;
    assign w_ptr_oh  = WAYS'(1) << r_ptr;
    assign w_ptr_nxt = (r_ptr == PTR_W'(WAYS - 1)) ? '0 : r_ptr + 1'b1;
    assign w_ptr_adv = w_wr_acc && (wr_way == w_ptr_oh);

    // During the sweep the write port belongs to the invalidator.
    assign w_wset  = busy ? r_sweep_set : wr_set;
    assign w_wdata = busy ? '0 : {1'b1, wr_tag};
    assign w_we    = busy ? {WAYS{1'b1}} : (wr_way & {WAYS{w_wr_acc}});

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            ic_tag_way #(
                .SETS  (SETS),
                .TAG_W (TAG_W),
                .IMPL  (IMPL)
            ) u_way (
                .clk     (clk),
                .rst_n   (rst_n),
                .rd_en   (w_rd_acc),
                .rd_set  (rd_set),
                .wr_en   (w_we[gi]),
                .wr_set  (w_wset),
                .wr_data (w_wdata),
                .rd_data (w_rdata[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state     <= SWEEP;
            r_sweep_set <= '0;
        end else if (r_state == SWEEP) begin
            if (r_sweep_set == SET_W'(SETS - 1)) begin
                r_state <= IDLE;
            end
            r_sweep_set <= r_sweep_set + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_ptr_adv) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Snapshot the pointer as it stands after this cycle's fill, matching the forwarded data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lk_valid <= 1'b0;
            r_res_ok   <= 1'b0;
            r_tag      <= '0;
            r_ptr_snap <= '0;
        end else begin
            r_lk_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_res_ok   <= 1'b1;
                r_tag      <= rd_tag;
                r_ptr_snap <= w_ptr_adv ? w_ptr_nxt : r_ptr;
            end
        end
    end

    always_comb begin
        w_match   = '0;
        w_invalid = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            w_match[i]   = w_rdata[i][TAG_W] && (w_rdata[i][TAG_W-1:0] == r_tag);
            w_invalid[i] = ~w_rdata[i][TAG_W];
        end
    end

    assign lk_valid = r_lk_valid;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        multi_hit  = 1'b0;
        victim_way = '0;
        if (r_res_ok) begin
            hit        = |w_match;
            hit_way    = w_match & (~w_match + 1'b1);
            multi_hit  = |(w_match & (w_match - 1'b1));
            victim_way = (|w_invalid) ? (w_invalid & (~w_invalid + 1'b1))
                                      : (WAYS'(1) << r_ptr_snap);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ic_tag_array.sv
// ============================================================================
// Module   : tb_ic_tag_array
// Purpose  : Randomised scoreboard bench for ic_tag_array (WAYS=4, SETS=256).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ic_tag_array;
    localparam int WAYS  = 4;
    localparam int SETS  = 256;
    localparam int TAG_W = 15;
    localparam int SET_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rd_en;
    logic [SET_W-1:0] rd_set;
    logic [TAG_W-1:0] rd_tag;
    logic             lk_valid;
    logic             hit;
    logic [WAYS-1:0]  hit_way;
    logic             multi_hit;
    logic [WAYS-1:0]  victim_way;
    logic             wr_en;
    logic [SET_W-1:0] wr_set;
    logic [WAYS-1:0]  wr_way;
    logic [TAG_W-1:0] wr_tag;
    logic             flush;
    logic             busy;

    always #5 clk = ~clk;

    ic_tag_array #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IMPL  (ic_pkg::BEHAVIORAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_set     (rd_set),
        .rd_tag     (rd_tag),
        .lk_valid   (lk_valid),
        .hit        (hit),
        .hit_way    (hit_way),
        .multi_hit  (multi_hit),
        .victim_way (victim_way),
        .wr_en      (wr_en),
        .wr_set     (wr_set),
        .wr_way     (wr_way),
        .wr_tag     (wr_tag),
        .flush      (flush),
        .busy       (busy)
    );

    typedef struct {
        int             due;
        bit             lk;
        bit             hit;
        logic [WAYS-1:0] hw;
        bit             mh;
        logic [WAYS-1:0] vw;
    } exp_t;

    exp_t q[$];
    exp_t hold;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model: contents per set/way, round-robin pointer, remaining sweep cycles.
    bit   m_val [SETS][WAYS];
    int   m_tag [SETS][WAYS];
    int   m_ptr;
    int   sweep_left;
    bit   state_known;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                m_val[s][w] = 1'b0;
    endtask

    task automatic step(input bit rn, input bit rd, input int rs, input int rt,
                        input bit wr, input int ws, input logic [WAYS-1:0] ww,
                        input int wt, input bit fl);
        exp_t e;
        bit   b;
        int   cnt;
        logic [WAYS-1:0] mt, inv;
        rst_n  = rn;
        rd_en  = rd;
        rd_set = rs[SET_W-1:0];
        rd_tag = rt[TAG_W-1:0];
        wr_en  = wr;
        wr_set = ws[SET_W-1:0];
        wr_way = ww;
        wr_tag = wt[TAG_W-1:0];
        flush  = fl;
        @(negedge clk);
        if (state_known) chk("busy", {31'b0, busy}, {31'b0, sweep_left > 0});
        e     = hold;
        e.due = cyc + 1;
        e.lk  = 1'b0;
        if (!rn) begin
            model_clear();
            m_ptr       = 0;
            sweep_left  = SETS;
            hold        = '{default: 0};
            e           = hold;
            e.due       = cyc + 1;
            state_known = 1'b1;
        end else begin
            b = (sweep_left > 0);
            if (wr && !b) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (ww[w]) begin
                        m_val[ws][w] = 1'b1;
                        m_tag[ws][w] = wt;
                    end
                end
                if (int'(ww) == (1 << m_ptr)) m_ptr = (m_ptr + 1) % WAYS;
            end
            if (rd && !b) begin
                mt  = '0;
                inv = '0;
                cnt = 0;
                for (int w = 0; w < WAYS; w++) begin
                    if (m_val[rs][w] && m_tag[rs][w] == rt) begin
                        mt[w] = 1'b1;
                        cnt++;
                    end
                    if (!m_val[rs][w]) inv[w] = 1'b1;
                end
                e.hit = (cnt > 0);
                e.mh  = (cnt > 1);
                e.hw  = '0;
                for (int w = WAYS - 1; w >= 0; w--) if (mt[w]) e.hw = WAYS'(1 << w);
                e.vw  = WAYS'(1 << m_ptr);
                for (int w = WAYS - 1; w >= 0; w--) if (inv[w]) e.vw = WAYS'(1 << w);
                hold  = e;
                e.lk  = 1'b1;
            end
            if (fl) begin
                sweep_left = SETS;
                model_clear();
            end else if (sweep_left > 0) begin
                sweep_left--;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic lookup(input int s, input int t);
        step(1, 1, s, t, 0, 0, '0, 0, 0);
    endtask

    task automatic fill(input int s, input logic [WAYS-1:0] w, input int t);
        step(1, 0, 0, 0, 1, s, w, t, 0);
    endtask

    // Monitor: compares every cycle's outputs with the entry due that cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due == cyc) begin
                chk("lk_valid",   {31'b0, lk_valid},   {31'b0, e.lk});
                chk("hit",        {31'b0, hit},        {31'b0, e.hit});
                chk("hit_way",    {28'b0, hit_way},    {28'b0, e.hw});
                chk("multi_hit",  {31'b0, multi_hit},  {31'b0, e.mh});
                chk("victim_way", {28'b0, victim_way}, {28'b0, e.vw});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [WAYS-1:0] ww;
        state_known = 1'b0;
        hold        = '{default: 0};
        sweep_left  = SETS;
        m_ptr       = 0;
        model_clear();
        rst_n = 1'b0; rd_en = 1'b0; rd_set = '0; rd_tag = '0;
        wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_tag = '0; flush = 1'b0;
        @(posedge clk);
        #1;

        repeat (3) step(0, 0, 0, 0, 0, 0, '0, 0, 0);
        // Accesses during the power-up sweep must be dropped.
        repeat (10) idle();
        step(1, 1, 9, 'h77, 1, 9, 4'b0001, 'h77, 0);
        while (sweep_left > 0) idle();
        lookup(9, 'h77);
        lookup(0, 'h12);

        fill(5, 4'b0100, 'h1A3);
        lookup(5, 'h1A3);
        lookup(5, 'h1A4);

        step(1, 1, 7, 'h55, 1, 7, 4'b0010, 'h55, 0);
        idle();

        for (int w = 0; w < WAYS; w++) fill(3, WAYS'(1 << w), 'h300 + w);
        for (int k = 0; k < 5; k++) begin
            lookup(3, 'h999);
            fill(3, WAYS'(1 << (k % WAYS)), 'h400 + k);
        end

        // Lookup coincident with flush still sees pre-sweep data.
        step(1, 1, 5, 'h1A3, 0, 0, '0, 0, 1);
        repeat (100) idle();
        step(1, 0, 0, 0, 0, 0, '0, 0, 1);
        while (sweep_left > 0) idle();
        lookup(5, 'h1A3);
        lookup(7, 'h55);
        lookup(3, 'h404);
        lookup(255, 0);

        // Reset in the middle of a sweep.
        step(1, 0, 0, 0, 0, 0, '0, 0, 1);
        repeat (20) idle();
        repeat (2) step(0, 1, 1, 1, 1, 1, 4'b0001, 1, 0);
        while (sweep_left > 0) idle();
        lookup(1, 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) ww = WAYS'($urandom_range(1, 15));
            else                          ww = WAYS'(1 << $urandom_range(0, 3));
            step(($urandom_range(0, 1499) != 0),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 7), ww, $urandom_range(0, 3),
                 ($urandom_range(0, 499) == 0));
        end
        repeat (3) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
